// File: rtl/fault_injection_cell.sv
`default_nettype none
// ============================================================================
// Module   : fault_injection_cell
// Brief    : Four-input test circuit (out = ~(a&b) & (e|f)) evaluated as a
//            fault-free copy and a faulty copy carrying one parameter-selected
//            stuck-at or transition fault. Both outputs and their XOR are
//            registered.
// Revision : 1.0 - initial release
// ============================================================================
module fault_injection_cell #(
    parameter int FAULT_TYPE = 0,   // 0 none, 1 SA0, 2 SA1, 3 STR, 4 STF, 5-7 none
    parameter int FAULT_SITE = 0    // 0 a, 1 b, 2 e, 3 f, 4 c, 5 d, 6 g, 7 none
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic e,
    input  logic f,
    output logic y,
    output logic y_ref,
    output logic mismatch
);

    // Site ordering of the history vector: {g, d, c, f, e, b, a}.
    // Reset history is the fault-free net state for all-zero inputs (g = 1).
    localparam logic [6:0] c_prev_reset   = 7'b100_0000;
    localparam bit         c_fault_active = (FAULT_SITE >= 0) && (FAULT_SITE < 7) &&
                                            (FAULT_TYPE >= 1) && (FAULT_TYPE <= 4);

    logic [6:0] r_prev_good;
    logic [6:0] w_good;
    logic       w_good_out;
    logic       w_fa, w_fb, w_fe, w_ff, w_fc, w_fd, w_fg;
    logic       w_faulty_out;

    // Replace a net value when it is the faulted site. Transition faults
    // compare the fault-free history against the current fault-free value,
    // so a delayed edge only lasts one evaluation.
    function automatic logic inject(input logic pre_v, input logic good_v,
                                    input logic prev_v, input int idx);
        logic v;
        v = pre_v;
        if (c_fault_active && (idx == FAULT_SITE)) begin
            case (FAULT_TYPE)
                1:       v = 1'b0;
                2:       v = 1'b1;
                3:       v = (!prev_v && good_v) ? 1'b0 : good_v;
                4:       v = (prev_v && !good_v) ? 1'b1 : good_v;
                default: v = pre_v;
            endcase
        end
        return v;
    endfunction

    // Fault-free copy of every net plus the faulty copy in topological order.
    always_comb begin
        w_good[0]  = a;
        w_good[1]  = b;
        w_good[2]  = e;
        w_good[3]  = f;
        w_good[4]  = a & b;
        w_good[5]  = e | f;
        w_good[6]  = ~(a & b);
        w_good_out = w_good[6] & w_good[5];

        w_fa = inject(a,           w_good[0], r_prev_good[0], 0);
        w_fb = inject(b,           w_good[1], r_prev_good[1], 1);
        w_fe = inject(e,           w_good[2], r_prev_good[2], 2);
        w_ff = inject(f,           w_good[3], r_prev_good[3], 3);
        w_fc = inject(w_fa & w_fb, w_good[4], r_prev_good[4], 4);
        w_fd = inject(w_fe | w_ff, w_good[5], r_prev_good[5], 5);
        w_fg = inject(~w_fc,       w_good[6], r_prev_good[6], 6);
        w_faulty_out = w_fg & w_fd;
    end

    // Capture both circuit outputs, their difference and the fault-free history.
    always_ff @(posedge clk) begin
        if (rst) begin
            y           <= 1'b0;
            y_ref       <= 1'b0;
            mismatch    <= 1'b0;
            r_prev_good <= c_prev_reset;
        end else begin
            y           <= w_faulty_out;
            y_ref       <= w_good_out;
            mismatch    <= w_faulty_out ^ w_good_out;
            r_prev_good <= w_good;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fault_injection_cell.sv
`default_nettype none
// ============================================================================
// Module   : tb_fault_injection_cell
// Brief    : Bench for fault_injection_cell. Several instances with different
//            fault configurations share one input bus; directed vectors and
//            random traffic are checked against a net-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fault_injection_cell;

    localparam int N = 13;
    localparam int TYPES [N] = '{0, 2, 1, 3, 4, 4, 2, 3, 1, 2, 5, 3, 4};
    localparam int SITES [N] = '{0, 5, 6, 3, 5, 0, 4, 2, 1, 7, 3, 6, 6};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, e = 1'b0, f = 1'b0;
    logic [N-1:0] ys, yrs, mms;

    int checks   = 0;
    int failures = 0;

    logic [6:0] model_prev [N];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            fault_injection_cell #(
                .FAULT_TYPE(TYPES[gi]),
                .FAULT_SITE(SITES[gi])
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .a        (a),
                .b        (b),
                .e        (e),
                .f        (f),
                .y        (ys[gi]),
                .y_ref    (yrs[gi]),
                .mismatch (mms[gi])
            );
        end
    endgenerate

    // Reference: evaluate the netlist net by net; the fault overrides its
    // site and downstream nets see the overridden value.
    function automatic void model_eval(input int t, input int s, input logic [3:0] abef,
                                       input logic [6:0] prev, output logic [6:0] good,
                                       output logic yo, output logic yr);
        logic [6:0] fn;
        logic       v;
        bit         active;
        active  = (s < 7) && (t >= 1) && (t <= 4);
        good[0] = abef[3];
        good[1] = abef[2];
        good[2] = abef[1];
        good[3] = abef[0];
        good[4] = good[0] && good[1];
        good[5] = good[2] || good[3];
        good[6] = !good[4];
        fn = '0;
        for (int k = 0; k < 7; k++) begin
            if (k < 4)       v = good[k];
            else if (k == 4) v = fn[0] && fn[1];
            else if (k == 5) v = fn[2] || fn[3];
            else             v = !fn[4];
            if (active && k == s) begin
                if (t == 1)      v = 1'b0;
                else if (t == 2) v = 1'b1;
                else if (t == 3) v = (prev[k] == 1'b0 && good[k] == 1'b1) ? 1'b0 : good[k];
                else             v = (prev[k] == 1'b1 && good[k] == 1'b0) ? 1'b1 : good[k];
            end
            fn[k] = v;
        end
        yo = fn[6] && fn[5];
        yr = good[6] && good[5];
    endfunction

    // Drive one cycle of stimulus and advance the reference model.
    task automatic apply(input logic r, input logic [3:0] abef);
        logic [6:0] good;
        logic       yo, yr;
        @(negedge clk);
        rst = r;
        {a, b, e, f} = abef;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (r) begin
                model_prev[i] = 7'b100_0000;
            end else begin
                model_eval(TYPES[i], SITES[i], abef, model_prev[i], good, yo, yr);
                model_prev[i] = good;
            end
        end
    endtask

    function automatic logic [2:0] model_out(input int i, input logic r, input logic [3:0] abef,
                                             input logic [6:0] prev);
        logic [6:0] good;
        logic       yo, yr;
        if (r) return 3'b000;
        model_eval(TYPES[i], SITES[i], abef, prev, good, yo, yr);
        return {yo, yr, yo ^ yr};
    endfunction

    typedef struct {
        int         dut;
        logic       r;
        logic [3:0] abef;
        logic [2:0] exp;    // {y, y_ref, mismatch}
    } vec_t;

    vec_t vecs [$];

    initial begin
        logic [2:0] act, expv;
        logic [3:0] abef;
        logic       r;
        logic [6:0] snap [N];

        // Directed vectors, expected values taken straight from the circuit rules.
        vecs = '{
            '{0, 1'b1, 4'b0000, 3'b000},
            '{0, 1'b0, 4'b0110, 3'b110},
            '{0, 1'b0, 4'b0111, 3'b110},
            '{0, 1'b0, 4'b0000, 3'b000},
            '{0, 1'b0, 4'b0001, 3'b110},
            '{1, 1'b1, 4'b1111, 3'b000},
            '{1, 1'b0, 4'b0000, 3'b101},
            '{1, 1'b0, 4'b0110, 3'b110},
            '{2, 1'b1, 4'b0000, 3'b000},
            '{2, 1'b0, 4'b0110, 3'b011},
            '{3, 1'b1, 4'b0000, 3'b000},
            '{3, 1'b0, 4'b0000, 3'b000},
            '{3, 1'b0, 4'b0001, 3'b011},
            '{3, 1'b0, 4'b0001, 3'b110},
            '{4, 1'b1, 4'b0000, 3'b000},
            '{4, 1'b0, 4'b0110, 3'b110},
            '{4, 1'b0, 4'b0000, 3'b101},
            '{4, 1'b0, 4'b0000, 3'b000},
            '{4, 1'b1, 4'b0000, 3'b000},
            '{4, 1'b0, 4'b0110, 3'b110},
            '{4, 1'b1, 4'b0110, 3'b000},
            '{4, 1'b0, 4'b0000, 3'b000}
        };

        for (int i = 0; i < N; i++) model_prev[i] = 7'b100_0000;

        for (int v = 0; v < vecs.size(); v++) begin
            apply(vecs[v].r, vecs[v].abef);
            act = {ys[vecs[v].dut], yrs[vecs[v].dut], mms[vecs[v].dut]};
            checks++;
            if (act !== vecs[v].exp) begin
                failures++;
                $display("FAIL directed[%0d] dut=%0d abef=%b rst=%b actual y,y_ref,mm=%b required=%b",
                         v, vecs[v].dut, vecs[v].abef, vecs[v].r, act, vecs[v].exp);
            end
        end

        // Random traffic with occasional resets, all instances against the model.
        for (int c = 0; c < 400; c++) begin
            abef = 4'($urandom_range(0, 15));
            r    = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < N; i++) snap[i] = model_prev[i];
            apply(r, abef);
            for (int i = 0; i < N; i++) begin
                expv = model_out(i, r, abef, snap[i]);
                act  = {ys[i], yrs[i], mms[i]};
                checks++;
                if (act !== expv) begin
                    failures++;
                    $display("FAIL random[%0d] dut=%0d type=%0d site=%0d abef=%b rst=%b actual=%b required=%b",
                             c, i, TYPES[i], SITES[i], abef, r, act, expv);
                end
            end
        end

        // Inputs wiggled between edges must not disturb registered outputs.
        apply(1'b0, 4'b0001);
        for (int i = 0; i < N; i++) snap[i] = model_prev[i];
        act = {ys[0], yrs[0], mms[0]};
        #2 {a, b, e, f} = 4'b1100;
        #1;
        checks++;
        if ({ys[0], yrs[0], mms[0]} !== act || act !== 3'b110) begin
            failures++;
            $display("FAIL hold_between_edges actual=%b required=%b", {ys[0], yrs[0], mms[0]}, 3'b110);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fault_injection_cell.md
Name: fault_injection_cell

Overview:
- Four-input combinational test circuit wrapped with a single-site, parameter-selected fault model.
- Used as the device under fault simulation in ATPG pattern validation.
- Each clock, it evaluates a fault-free copy and a faulty copy of the circuit and registers both outputs, plus a mismatch flag.
- Supports stuck-at and transition-delay faults, so that two-pattern launch/capture sequences can be checked.

Parameters:
- FAULT_TYPE, default 0. Fault model: 0 none, 1 stuck-at-0, 2 stuck-at-1, 3 slow-to-rise, 4 slow-to-fall. Values 5–7 behave as 0.
- FAULT_SITE, default 0. Net carrying the fault: 0 a, 1 b, 2 e, 3 f, 4 c, 5 d, 6 g. Value 7 means no site, i.e. fault-free.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a  input  1  circuit primary input
- b  input  1  circuit primary input
- e  input  1  circuit primary input
- f  input  1  circuit primary input
- y  output  1  registered faulty-circuit output
- y_ref  output  1  registered fault-free output
- mismatch  output  1  registered, equals y XOR y_ref

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst. No asynchronous paths.
- Fault-free netlist:
  - c = a AND b
  - d = e OR f
  - g = NOT c
  - out = g AND d
- Faulty copy:
  - Evaluate nets in topological order: a, b, e, f, then c, d, then g, then out.
  - The fault replaces the value of the selected site. All downstream nets use the replaced value.
  - Stuck-at-0 forces the site to 0 every cycle. Stuck-at-1 forces it to 1.
- Transition faults:
  - Keep register prev_good[6:0], holding the fault-free value of every site from the previous evaluation.
  - Slow-to-rise: if prev_good[site]=0 and the current fault-free value is 1, the faulty site value is 0 for this evaluation only. Otherwise it equals the current fault-free value.
  - Slow-to-fall: symmetric (previous 1, current 0, faulty value 1).
  - prev_good always tracks fault-free values, so a held transition lasts exactly one cycle.
- Timing:
  - At each rising clk with rst=0, sample a, b, e, f.
  - Compute both copies from the sampled inputs.
  - Register y, y_ref and mismatch, and update prev_good.
  - Latency is 1 cycle: outputs reflect the inputs present at the previous rising edge.
  - Outputs are stable between edges. Input changes between edges have no effect.
- Reset, at a rising clk with rst=1:
  - y=0, y_ref=0, mismatch=0.
  - prev_good loads the fault-free values for all-zero inputs: a=b=e=f=0, c=0, d=0, g=1.
  - Inputs are ignored that cycle.
  - Reset asserted mid-sequence discards any pending transition history.
- Site 7 or FAULT_TYPE 0/5/6/7: the faulty copy equals the fault-free copy, so mismatch is always 0.
- A fault on a primary-input site affects only the faulty copy's view of that input. y_ref is never affected by any fault.

Test Plan:
- FAULT_TYPE=0, reset, then apply abef=0110, 0111, 0000, 0001 on successive cycles. Required: y = y_ref = 1, 1, 0, 1, one cycle after each input; mismatch = 0 throughout.
- FAULT_TYPE=2, FAULT_SITE=5 (d stuck-at-1), apply 0000. Required: y=1, y_ref=0, mismatch=1. Then apply 0110: y=1, y_ref=1, mismatch=0.
- FAULT_TYPE=1, FAULT_SITE=6 (g stuck-at-0), apply 0110. Required: y=0, y_ref=1, mismatch=1.
- FAULT_TYPE=3, FAULT_SITE=3 (f slow-to-rise), apply 0000 then 0001. Required on the second capture: y=0, y_ref=1, mismatch=1. Hold 0001 for one more cycle: y=1, mismatch=0.
- FAULT_TYPE=4, FAULT_SITE=5 (d slow-to-fall), apply 0110 then 0000. Required on the second capture: y=1, y_ref=0, mismatch=1. Next cycle with 0000: y=0, mismatch=0.
- Same configuration as the slow-to-fall case: apply 0110, assert rst for one cycle, then apply 0000. Required: outputs 0 during reset, then y=0, y_ref=0, mismatch=0, because the history was cleared.
